// File: rtl/vend_pkg.sv
// Shared state encoding and helpers for the multi-product vending controller.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_PAY      = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_RETURN   = 3'd4
    } state_t;

    localparam int MAX_PRODUCTS = 16;
    localparam int MAX_PRICE_W  = 16;
    localparam int ID_W         = 4;

    function automatic int timer_w(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    // Price tables of any width are widened to the maximum shape before lookup.
    function automatic logic [MAX_PRICE_W-1:0] price_at(
        input logic [MAX_PRODUCTS*MAX_PRICE_W-1:0] table_bits,
        input int                                  price_w,
        input int                                  idx
    );
        logic [MAX_PRODUCTS*MAX_PRICE_W-1:0] shifted;
        logic [MAX_PRICE_W-1:0]              mask;
        shifted = table_bits >> (idx * price_w);
        mask    = (MAX_PRICE_W'(1) << price_w) - MAX_PRICE_W'(1);
        return shifted[MAX_PRICE_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/vend_ctrl_multi_stock.sv
// Per-product stock counters: reset to INIT_STOCK, load, decrement, zero lookup.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int NUM_PRODUCTS = 8,
    parameter int STOCK_W      = 4,
    parameter int INIT_STOCK   = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               ld_en,
    input  logic [ID_W-1:0]    ld_id,
    input  logic [STOCK_W-1:0] ld_count,
    input  logic               dec_en,
    input  logic [ID_W-1:0]    dec_id,
    input  logic [ID_W-1:0]    rd_id,
    output logic               rd_zero
);

    logic [STOCK_W-1:0] stock [NUM_PRODUCTS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                if (ld_en && ld_id == ID_W'(i)) begin
                    stock[i] <= ld_count;
                end else if (dec_en && dec_id == ID_W'(i) && stock[i] != '0) begin
                    stock[i] <= stock[i] - 1'b1;
                end
            end
        end
    end

    // Out-of-range ids read as empty so they can never be sold.
    always_comb begin
        rd_zero = 1'b1;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (rd_id == ID_W'(i)) rd_zero = (stock[i] == '0);
        end
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: selection, coin/online payment, dispense and change.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                            NUM_PRODUCTS   = 8,
    parameter int                            PRICE_W        = 8,
    parameter int                            STOCK_W        = 4,
    parameter int                            INIT_STOCK     = 5,
    parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES       =
        {8'd25, 8'd30, 8'd5, 8'd20, 8'd20, 8'd35, 8'd50, 8'd10},
    parameter int                            TIMEOUT_CYCLES = 1000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_cancel,
    input  logic               i_sel_valid,
    input  logic [3:0]         i_sel_id,
    input  logic               i_coin_valid,
    input  logic [PRICE_W-1:0] i_coin_value,
    input  logic               i_online_pay,
    input  logic               i_restock_valid,
    input  logic [3:0]         i_restock_id,
    input  logic [STOCK_W-1:0] i_restock_count,
    output logic [2:0]         o_state,
    output logic [PRICE_W-1:0] o_credit,
    output logic [PRICE_W-1:0] o_price,
    output logic               o_dispense,
    output logic [3:0]         o_product_id,
    output logic               o_change_valid,
    output logic [PRICE_W-1:0] o_change_value,
    output logic               o_sold_out,
    output logic               o_coin_reject,
    output logic               o_timeout
);

    localparam int TIMER_W = timer_w(TIMEOUT_CYCLES);
    localparam logic [MAX_PRODUCTS*MAX_PRICE_W-1:0] PRICE_TABLE =
        (MAX_PRODUCTS*MAX_PRICE_W)'(PRICES);

    state_t             state;
    logic [PRICE_W-1:0] credit;
    logic [PRICE_W-1:0] price;
    logic [PRICE_W-1:0] change;
    logic [3:0]         sel_id;
    logic               paid_online;
    logic [TIMER_W-1:0] timer;

    logic               stock_zero;
    logic               restock_en;
    logic               sel_ok;
    logic [PRICE_W-1:0] sel_price;
    logic [PRICE_W:0]   coin_sum;
    logic               coin_seen;
    logic               coin_take;
    logic               tmo_hit;

    assign sel_price  = PRICE_W'(price_at(PRICE_TABLE, PRICE_W, int'(i_sel_id)));
    assign sel_ok     = (32'(i_sel_id) < NUM_PRODUCTS) && !stock_zero;
    assign restock_en = (state == ST_IDLE) && i_restock_valid
                        && (32'(i_restock_id) < NUM_PRODUCTS);
    assign tmo_hit    = ((state == ST_SELECT) || (state == ST_PAY))
                        && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    // A coin is only banked in a PAY cycle that stays on the payment path.
    assign coin_seen = i_coin_valid && (i_coin_value != '0);
    assign coin_sum  = {1'b0, credit} + {1'b0, i_coin_value};
    assign coin_take = coin_seen && (state == ST_PAY) && !i_cancel && !tmo_hit
                       && !coin_sum[PRICE_W];

    assign o_state  = state;
    assign o_credit = credit;
    assign o_price  = ((state == ST_PAY) || (state == ST_DISPENSE) || (state == ST_RETURN))
                      ? price : '0;

    vend_stock_bank #(
        .NUM_PRODUCTS (NUM_PRODUCTS),
        .STOCK_W      (STOCK_W),
        .INIT_STOCK   (INIT_STOCK)
    ) u_stock (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .ld_en    (restock_en),
        .ld_id    (i_restock_id),
        .ld_count (i_restock_count),
        .dec_en   (state == ST_DISPENSE),
        .dec_id   (sel_id),
        .rd_id    (i_sel_id),
        .rd_zero  (stock_zero)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            credit         <= '0;
            price          <= '0;
            change         <= '0;
            sel_id         <= '0;
            paid_online    <= 1'b0;
            timer          <= '0;
            o_dispense     <= 1'b0;
            o_product_id   <= '0;
            o_change_valid <= 1'b0;
            o_change_value <= '0;
            o_sold_out     <= 1'b0;
            o_coin_reject  <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            o_dispense     <= 1'b0;
            o_product_id   <= '0;
            o_change_valid <= 1'b0;
            o_change_value <= '0;
            o_sold_out     <= 1'b0;
            o_coin_reject  <= coin_seen && !coin_take;
            o_timeout      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (i_start) state <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (i_cancel) begin
                        change <= '0;
                        timer  <= '0;
                        state  <= ST_RETURN;
                    end else if (tmo_hit) begin
                        o_timeout <= 1'b1;
                        timer     <= '0;
                        state     <= ST_IDLE;
                    end else if (i_sel_valid && sel_ok) begin
                        sel_id <= i_sel_id;
                        price  <= sel_price;
                        timer  <= '0;
                        state  <= ST_PAY;
                    end else begin
                        o_sold_out <= i_sel_valid;
                        timer      <= timer + 1'b1;
                    end
                end
                ST_PAY: begin
                    if (i_cancel || tmo_hit) begin
                        o_timeout <= !i_cancel;
                        change    <= credit;
                        timer     <= '0;
                        state     <= ST_RETURN;
                    end else begin
                        if (coin_take) credit <= coin_sum[PRICE_W-1:0];
                        // Sufficiency is judged on the registered credit, before this cycle's coin.
                        if (i_online_pay) begin
                            paid_online <= 1'b1;
                            timer       <= '0;
                            state       <= ST_DISPENSE;
                        end else if (credit >= price) begin
                            timer <= '0;
                            state <= ST_DISPENSE;
                        end else if (coin_take) begin
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_DISPENSE: begin
                    o_dispense   <= 1'b1;
                    o_product_id <= sel_id;
                    change       <= paid_online ? credit : credit - price;
                    state        <= ST_RETURN;
                end
                ST_RETURN: begin
                    o_change_valid <= 1'b1;
                    o_change_value <= change;
                    credit         <= '0;
                    price          <= '0;
                    change         <= '0;
                    sel_id         <= '0;
                    paid_online    <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: begin
                    credit      <= '0;
                    price       <= '0;
                    change      <= '0;
                    sel_id      <= '0;
                    paid_online <= 1'b0;
                    timer       <= '0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed scenarios then randomized traffic against a cycle-level reference model.
module tb_vend_ctrl_multi;

    localparam int NP = 8;
    localparam int TO = 16;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start, i_cancel, i_sel_valid, i_coin_valid, i_online_pay, i_restock_valid;
    logic [3:0] i_sel_id, i_restock_id, i_restock_count;
    logic [7:0] i_coin_value;
    logic [2:0] o_state;
    logic [7:0] o_credit, o_price, o_change_value;
    logic       o_dispense, o_change_valid, o_sold_out, o_coin_reject, o_timeout;
    logic [3:0] o_product_id;

    vend_ctrl_multi #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_cancel(i_cancel),
        .i_sel_valid(i_sel_valid), .i_sel_id(i_sel_id), .i_coin_valid(i_coin_valid),
        .i_coin_value(i_coin_value), .i_online_pay(i_online_pay),
        .i_restock_valid(i_restock_valid), .i_restock_id(i_restock_id),
        .i_restock_count(i_restock_count), .o_state(o_state), .o_credit(o_credit),
        .o_price(o_price), .o_dispense(o_dispense), .o_product_id(o_product_id),
        .o_change_valid(o_change_valid), .o_change_value(o_change_value),
        .o_sold_out(o_sold_out), .o_coin_reject(o_coin_reject), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int n_vec  = 0;
    int n_miss = 0;

    int price_tab [NP] = '{10, 50, 35, 20, 20, 5, 30, 25};
    logic [7:0] coin_tab [8] = '{8'd0, 8'd5, 8'd10, 8'd20, 8'd25, 8'd50, 8'd100, 8'd230};

    // Reference model: phase 0 idle, 1 choosing, 2 paying, 3 vending, 4 giving change.
    int m_state, m_credit, m_price, m_sel, m_change, m_online, m_timer;
    int m_stock [NP];
    int e_disp, e_pid, e_chv, e_chval, e_so, e_cr, e_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_credit = 0; m_price = 0; m_sel = 0; m_change = 0;
        m_online = 0; m_timer = 0;
        for (int i = 0; i < NP; i++) m_stock[i] = 5;
        e_disp = 0; e_pid = 0; e_chv = 0; e_chval = 0; e_so = 0; e_cr = 0; e_to = 0;
    endtask

    task automatic model_step();
        int  cv, id, old_credit;
        bit  coin, took;
        cv   = int'(i_coin_value);
        coin = i_coin_valid && (cv != 0);
        id   = int'(i_sel_id);
        took = 0;
        old_credit = m_credit;
        e_disp = 0; e_pid = 0; e_chv = 0; e_chval = 0; e_so = 0; e_cr = 0; e_to = 0;
        case (m_state)
            0: begin
                e_cr = coin;
                if (i_restock_valid && int'(i_restock_id) < NP)
                    m_stock[int'(i_restock_id)] = int'(i_restock_count);
                if (i_start) begin m_state = 1; m_timer = 0; end
            end
            1: begin
                e_cr = coin;
                if (i_cancel) begin
                    m_change = 0; m_state = 4;
                end else if (m_timer == TO - 1) begin
                    e_to = 1; m_state = 0;
                end else if (i_sel_valid && id < NP && m_stock[id % NP] > 0) begin
                    m_sel = id; m_price = price_tab[id % NP]; m_state = 2; m_timer = 0;
                end else begin
                    e_so = i_sel_valid; m_timer++;
                end
            end
            2: begin
                if (i_cancel || m_timer == TO - 1) begin
                    e_cr = coin; e_to = !i_cancel; m_change = m_credit; m_state = 4;
                end else begin
                    if (coin) begin
                        if (m_credit + cv > 255) e_cr = 1;
                        else begin m_credit += cv; took = 1; end
                    end
                    if (i_online_pay) begin m_online = 1; m_state = 3; end
                    else if (old_credit >= m_price) m_state = 3;
                    if (m_state != 2 || took) m_timer = 0; else m_timer++;
                end
            end
            3: begin
                e_cr = coin; e_disp = 1; e_pid = m_sel; m_stock[m_sel]--;
                m_change = m_online ? m_credit : m_credit - m_price;
                m_state = 4;
            end
            default: begin
                e_cr = coin; e_chv = 1; e_chval = m_change;
                m_credit = 0; m_price = 0; m_online = 0; m_change = 0; m_state = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        check("state",      32'(o_state),        32'(m_state));
        check("credit",     32'(o_credit),       32'(m_credit));
        check("price",      32'(o_price),        (m_state >= 2) ? 32'(m_price) : 32'd0);
        check("dispense",   32'(o_dispense),     32'(e_disp));
        check("product_id", 32'(o_product_id),   32'(e_pid));
        check("chg_valid",  32'(o_change_valid), 32'(e_chv));
        check("chg_value",  32'(o_change_value), 32'(e_chval));
        check("sold_out",   32'(o_sold_out),     32'(e_so));
        check("coin_rej",   32'(o_coin_reject),  32'(e_cr));
        check("timeout",    32'(o_timeout),      32'(e_to));
    endtask

    task automatic clear_inputs();
        i_start = 0; i_cancel = 0; i_sel_valid = 0; i_sel_id = 0; i_coin_valid = 0;
        i_coin_value = 0; i_online_pay = 0; i_restock_valid = 0; i_restock_id = 0;
        i_restock_count = 0;
    endtask

    task automatic step();
        model_step();
        @(posedge i_clk);
        #1;
        compare_all();
        clear_inputs();
    endtask

    task automatic pulse_reset();
        clear_inputs();
        i_rst = 1;
        #1;
        model_reset();
        compare_all();
        @(posedge i_clk);
        #1;
        compare_all();
        i_rst = 0;
    endtask

    task automatic coin(input int v);
        i_coin_valid = 1; i_coin_value = 8'(v); step();
    endtask

    task automatic start_select(input int id);
        i_start = 1; step();
        i_sel_valid = 1; i_sel_id = 4'(id); step();
    endtask

    initial begin
        clear_inputs();
        i_rst = 1;
        model_reset();
        #1;
        compare_all();
        @(posedge i_clk);
        #1;
        i_rst = 0;

        // Exact-price purchase with overpay in the compare cycle.
        start_select(0);
        coin(5); coin(5); coin(5);
        check("tp1_credit", 32'(o_credit), 32'd15);
        step();
        check("tp1_dispense", 32'(o_dispense), 32'd1);
        step();
        check("tp1_change", 32'(o_change_value), 32'd5);

        // Cancel refunds credit, no vend.
        start_select(1);
        coin(20); coin(10);
        i_cancel = 1; step();
        step();
        check("tp2_change", 32'(o_change_value), 32'd30);

        // Sold-out and out-of-range selections.
        i_restock_valid = 1; i_restock_id = 2; i_restock_count = 0; step();
        start_select(2);
        check("tp3_sold_out", 32'(o_sold_out), 32'd1);
        i_sel_valid = 1; i_sel_id = 9; step();
        check("tp3_sold_out_id9", 32'(o_sold_out), 32'd1);
        i_cancel = 1; step();
        step();

        // Online payment refunds all coin credit.
        start_select(3);
        coin(10);
        i_online_pay = 1; step();
        step();
        check("tp4_pid", 32'(o_product_id), 32'd3);
        step();
        check("tp4_change", 32'(o_change_value), 32'd10);

        // PAY timeout, then a coin while idle.
        start_select(5);
        repeat (TO) step();
        check("tp5_timeout", 32'(o_timeout), 32'd1);
        step();
        i_coin_valid = 1; i_coin_value = 10; step();
        check("tp5_idle_coin", 32'(o_coin_reject), 32'd1);

        // SELECT timeout goes straight to idle.
        i_start = 1; step();
        repeat (TO) step();
        check("sel_timeout_state", 32'(o_state), 32'd0);

        // Overflowing coin is rejected, then reset mid-PAY.
        start_select(1);
        coin(20); coin(20); coin(230);
        check("tp6_credit", 32'(o_credit), 32'd40);
        pulse_reset();
        check("tp6_rst_credit", 32'(o_credit), 32'd0);
        start_select(2);
        check("tp6_restocked", 32'(o_state), 32'd2);
        i_cancel = 1; step();
        step();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
            end else begin
                i_start         = ($urandom_range(0, 3) == 0);
                i_cancel        = ($urandom_range(0, 39) == 0);
                i_sel_valid     = ($urandom_range(0, 2) == 0);
                i_sel_id        = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15))
                                                               : 4'($urandom_range(0, 7));
                i_coin_valid    = ($urandom_range(0, 2) == 0);
                i_coin_value    = coin_tab[$urandom_range(0, 7)];
                i_online_pay    = ($urandom_range(0, 49) == 0);
                i_restock_valid = ($urandom_range(0, 9) == 0);
                i_restock_id    = 4'($urandom_range(0, 9));
                i_restock_count = 4'($urandom_range(0, 6));
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
